// File: rtl/regfile_pkg.sv
// Shared register-file types and default sizing for the decode-stage
// register file and its writeback controller.
package regfile_pkg;

   localparam int unsigned REG_WIDTH_DEFAULT = 32;
   localparam int unsigned NUM_REGS_DEFAULT  = 32;

   // Writeback source selected by the arbiter
   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   // The source that is favoured after the given one wins a contended grant
   function automatic wb_src_e wb_src_other(input wb_src_e src);
      return (src == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
   endfunction

endpackage

// File: rtl/writeback_controller_if.sv
// Handshake and register-file write-port bundle for writeback_controller.
// The master side is decode/ALU/LSU plus whatever observes the write port;
// the slave side is the controller itself.
interface writeback_controller_if
   import regfile_pkg::*;
#(
   parameter int unsigned REG_WIDTH  = REG_WIDTH_DEFAULT,
   parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) ();

   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic                  issue_ready;

   logic                  alu_valid;
   logic [ADDR_WIDTH-1:0] alu_addr;
   logic [REG_WIDTH-1:0]  alu_data;
   logic                  alu_ready;

   logic                  lsu_valid;
   logic [ADDR_WIDTH-1:0] lsu_addr;
   logic [REG_WIDTH-1:0]  lsu_data;
   logic                  lsu_ready;

   logic                  rf_write_enable;
   logic [ADDR_WIDTH-1:0] rf_write_addr;
   logic [REG_WIDTH-1:0]  rf_write_data;

   modport master (
      output issue_valid, issue_addr,
      output alu_valid, alu_addr, alu_data,
      output lsu_valid, lsu_addr, lsu_data,
      input  issue_ready, alu_ready, lsu_ready,
      input  rf_write_enable, rf_write_addr, rf_write_data
   );

   modport slave (
      input  issue_valid, issue_addr,
      input  alu_valid, alu_addr, alu_data,
      input  lsu_valid, lsu_addr, lsu_data,
      output issue_ready, alu_ready, lsu_ready,
      output rf_write_enable, rf_write_addr, rf_write_data
   );

endinterface

// File: rtl/wb_arbiter.sv
// Two-input round-robin arbiter between the ALU and LSU writeback sources.
// Grants are combinational from the valids and a 1-bit pointer; the pointer
// only moves when both sources compete.
module wb_arbiter
   import regfile_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    alu_valid,
   input  logic    lsu_valid,
   output logic    alu_grant,
   output logic    lsu_grant,
   output wb_src_e sel
);

   wb_src_e ptr;
   wb_src_e ptr_next;

   // Pointer register; reset favours the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= WB_SRC_ALU;
      end else begin
         ptr <= ptr_next;
      end
   end

   // Grant selection and pointer advance on contended grants only
   always_comb begin
      alu_grant = 1'b0;
      lsu_grant = 1'b0;
      ptr_next  = ptr;
      if (alu_valid && lsu_valid) begin
         if (ptr == WB_SRC_ALU) begin
            alu_grant = 1'b1;
         end else begin
            lsu_grant = 1'b1;
         end
         ptr_next = wb_src_other(ptr);
      end else begin
         alu_grant = alu_valid;
         lsu_grant = lsu_valid;
      end
      sel = lsu_grant ? WB_SRC_LSU : WB_SRC_ALU;
   end

endmodule

// File: rtl/writeback_controller.sv
// Write-side controller for the decode-stage register file: arbitrates ALU
// and LSU results onto the single write port through one registered stage,
// and tracks which registers still have a result in flight.
module writeback_controller
   import regfile_pkg::*;
#(
   parameter int unsigned REG_WIDTH       = REG_WIDTH_DEFAULT,
   parameter int unsigned NUM_REGS        = NUM_REGS_DEFAULT,
   parameter int unsigned ADDR_WIDTH      = $clog2(NUM_REGS),
   parameter bit          REG_ZERO_GROUND = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   writeback_controller_if.slave wb,
   output logic [NUM_REGS-1:0]  busy,
   output logic                 wb_error
);

   logic                  alu_grant;
   logic                  lsu_grant;
   wb_src_e               sel;

   logic                  accept;
   logic                  wb_zero;
   logic                  wb_commit;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [REG_WIDTH-1:0]  wb_data;

   logic                  issue_zero;
   logic                  issue_ok;
   logic                  issue_fire;
   logic [NUM_REGS-1:0]   busy_next;

   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [REG_WIDTH-1:0]  data_q;

   wb_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (wb.alu_valid),
      .lsu_valid (wb.lsu_valid),
      .alu_grant (alu_grant),
      .lsu_grant (lsu_grant),
      .sel       (sel)
   );

   assign wb.alu_ready       = alu_grant;
   assign wb.lsu_ready       = lsu_grant;
   assign wb.issue_ready     = issue_ok;
   assign wb.rf_write_enable = we_q;
   assign wb.rf_write_addr   = addr_q;
   assign wb.rf_write_data   = data_q;

   // Source mux; a grounded register-0 writeback is accepted but never written
   always_comb begin
      accept    = alu_grant | lsu_grant;
      wb_addr   = (sel == WB_SRC_LSU) ? wb.lsu_addr : wb.alu_addr;
      wb_data   = (sel == WB_SRC_LSU) ? wb.lsu_data : wb.alu_data;
      wb_zero   = REG_ZERO_GROUND && (wb_addr == '0);
      wb_commit = accept && !wb_zero;
   end

   // Reservation acceptance: a register whose write lands this cycle is
   // already free, so it can be re-reserved in the same cycle
   always_comb begin
      issue_zero = REG_ZERO_GROUND && (wb.issue_addr == '0);
      issue_ok   = issue_zero || !busy[wb.issue_addr] ||
                   (we_q && (addr_q == wb.issue_addr));
      issue_fire = wb.issue_valid && issue_ok && !issue_zero;
   end

   // Scoreboard next state: clear on landing write, then set wins on overlap
   always_comb begin
      busy_next = busy;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (we_q && (addr_q == ADDR_WIDTH'(i))) begin
            busy_next[i] = 1'b0;
         end
         if (issue_fire && (wb.issue_addr == ADDR_WIDTH'(i))) begin
            busy_next[i] = 1'b1;
         end
      end
   end

   // Write stage: one-cycle enable pulse; addr/data hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q <= wb_commit;
         if (wb_commit) begin
            addr_q <= wb_addr;
            data_q <= wb_data;
         end
      end
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Sticky flag for a writeback to a register with no reservation
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_error <= 1'b0;
      end else if (wb_commit && !busy[wb_addr]) begin
         wb_error <= 1'b1;
      end
   end

endmodule
